// File: rtl/hamming_pkg.sv
// Shared widths, source encoding and the syndrome-to-bit map for the Hamming(7,4) decoder.
// Code layout is [6:3] data, [2:0] check bits.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Bit position to flip for each syndrome value; entry 0 is never used (no error).
  localparam logic [7:0][2:0] SYN_TO_BIT = {
    3'd6,  // 7
    3'd5,  // 6
    3'd4,  // 5
    3'd2,  // 4
    3'd3,  // 3
    3'd1,  // 2
    3'd0,  // 1
    3'd0   // 0
  };

  typedef struct packed {
    logic [CODE_W-1:0] code;
    src_e              src;
  } s1_word_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    src_e              src;
    logic              corrected;
  } out_word_t;

  function automatic logic [2:0] calc_syndrome(input logic [CODE_W-1:0] c);
    return {c[6] ^ c[5] ^ c[4] ^ c[2],
            c[6] ^ c[5] ^ c[3] ^ c[1],
            c[6] ^ c[4] ^ c[3] ^ c[0]};
  endfunction

endpackage

// File: rtl/hamming_7_4_decode_arbiter_if.sv
// Bundle of the two requester handshakes, the decoded output stream and the error counters.
// master = traffic source/sink side, slave = decoder side.
interface hamming_7_4_decode_arbiter_if
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              a_valid;
  logic              a_ready;
  logic [CODE_W-1:0] a_code;
  logic              b_valid;
  logic              b_ready;
  logic [CODE_W-1:0] b_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_corrected;
  logic              cnt_clr;
  logic [CNT_W-1:0]  err_cnt_a;
  logic [CNT_W-1:0]  err_cnt_b;

  modport master (
    output a_valid, a_code, b_valid, b_code, out_ready, cnt_clr,
    input  a_ready, b_ready, out_valid, out_data, out_src, out_corrected,
           err_cnt_a, err_cnt_b
  );

  modport slave (
    input  a_valid, a_code, b_valid, b_code, out_ready, cnt_clr,
    output a_ready, b_ready, out_valid, out_data, out_src, out_corrected,
           err_cnt_a, err_cnt_b
  );

endinterface

// File: rtl/hamming_7_4_syndrome_fix.sv
// Combinational Hamming(7,4) single-error correction: code in, data + corrected flag out.
// Zero latency, no handshake.
module hamming_7_4_syndrome_fix
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              corrected
);

  logic [2:0]        idx;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    idx       = calc_syndrome(code);
    flip_mask = '0;
    // Syndrome values are not bit positions, so the flip goes through the lookup table.
    if (idx != 3'd0) begin
      flip_mask[SYN_TO_BIT[idx]] = 1'b1;
    end
    fixed     = code ^ flip_mask;
    data      = fixed[CODE_W-1:CODE_W-DATA_W];
    corrected = (idx != 3'd0);
  end

endmodule

// File: rtl/hamming_7_4_decode_arbiter.sv
// Round-robin shares one Hamming(7,4) decoder between sources A/B; 2-cycle accept-to-output latency.
// Backpressure: out_ready low stalls S2 then S1, after which the granted source sees ready=0.
module hamming_7_4_decode_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                         clk,
  input logic                         rst_n,
  hamming_7_4_decode_arbiter_if.slave bus
);

  src_e              last_src;
  logic              run;
  logic              grant_a;
  logic              grant_b;
  logic              s1_free;
  logic              s2_free;
  logic              accept;
  src_e              acc_src;

  logic              s1_valid;
  s1_word_t          s1_r;
  logic              out_valid_r;
  out_word_t         out_r;

  logic [DATA_W-1:0] fix_data;
  logic              fix_corr;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;

  always_comb begin
    grant_a = bus.a_valid & (!bus.b_valid | (last_src == SRC_B));
    grant_b = bus.b_valid & (!bus.a_valid | (last_src == SRC_A));
  end

  assign s2_free = !out_valid_r | bus.out_ready;
  assign s1_free = !s1_valid | s2_free;

  // run holds ready low until the first clock after reset release.
  assign bus.a_ready = run & grant_a & s1_free;
  assign bus.b_ready = run & grant_b & s1_free;
  assign accept      = (bus.a_valid & bus.a_ready) | (bus.b_valid & bus.b_ready);
  assign acc_src     = bus.b_ready ? SRC_B : SRC_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      last_src <= SRC_B;
    end else begin
      run <= 1'b1;
      if (accept) begin
        last_src <= acc_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (s1_free) begin
      s1_valid <= accept;
      if (accept) begin
        s1_r.code <= acc_src == SRC_B ? bus.b_code : bus.a_code;
        s1_r.src  <= acc_src;
      end
    end
  end

  hamming_7_4_syndrome_fix u_fix (
    .code      (s1_r.code),
    .data      (fix_data),
    .corrected (fix_corr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else if (s2_free) begin
      out_valid_r <= s1_valid;
      if (s1_valid) begin
        out_r.data      <= fix_data;
        out_r.src       <= s1_r.src;
        out_r.corrected <= fix_corr;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (bus.cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (out_valid_r & bus.out_ready & out_r.corrected) begin
      if (out_r.src == SRC_A) begin
        if (cnt_a != '1) begin
          cnt_a <= cnt_a + CNT_W'(1);
        end
      end else begin
        if (cnt_b != '1) begin
          cnt_b <= cnt_b + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_r.data;
  assign bus.out_src       = out_r.src;
  assign bus.out_corrected = out_r.corrected;
  assign bus.err_cnt_a     = cnt_a;
  assign bus.err_cnt_b     = cnt_b;

endmodule

// File: tb/tb_hamming_7_4_decode_arbiter.sv
// Scoreboard bench for the shared Hamming(7,4) decoder: reference decode by brute-force search.
module tb_hamming_7_4_decode_arbiter;
  import hamming_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hamming_7_4_decode_arbiter_if #(.CNT_W(CW)) bus ();

  hamming_7_4_decode_arbiter #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       src;
    logic [3:0] data;
    logic       corr;
    int         acc_cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] a_stim_q[$];
  logic [6:0] b_stim_q[$];

  int n_chk = 0, n_pass = 0, cycle = 0, last_stall = -1;
  int excl_viol = 0, alt_viol = 0, hold_viol = 0, spurious = 0;
  int tp_first = -1, tp_last = -1;
  logic a_hs = 1'b0, b_hs = 1'b0, last_src = 1'b1, prev_stall = 1'b0;
  logic [5:0] prev_out = '0;
  logic [CW-1:0] exp_cnt_a = '0, exp_cnt_b = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
  endfunction

  function automatic logic [2:0] syn(input logic [6:0] c);
    return {c[6] ^ c[5] ^ c[4] ^ c[2], c[6] ^ c[5] ^ c[3] ^ c[1], c[6] ^ c[4] ^ c[3] ^ c[0]};
  endfunction

  // Returns {corrected, data}; searches for the single flip that yields a clean codeword.
  function automatic logic [4:0] ref_dec(input logic [6:0] c);
    logic [6:0] t;
    if (syn(c) == 3'd0) return {1'b0, c[6:3]};
    for (int i = 0; i < 7; i++) begin
      t = c ^ (7'(1) << i);
      if (syn(t) == 3'd0) return {1'b1, t[6:3]};
    end
    return {1'b1, c[6:3]};
  endfunction

  function automatic logic [6:0] mk_code(input logic [3:0] d, input int flip);
    logic [6:0] c;
    c = enc(d);
    if (flip < 7) c = c ^ (7'(1) << flip);
    return c;
  endfunction

  // Source drivers: present queue heads, pop after an observed handshake.
  initial begin
    bus.a_valid = 1'b0; bus.a_code = '0;
    bus.b_valid = 1'b0; bus.b_code = '0;
    forever begin
      @(posedge clk);
      #1;
      if (a_hs && a_stim_q.size() > 0) a_stim_q.delete(0);
      if (b_hs && b_stim_q.size() > 0) b_stim_q.delete(0);
      bus.a_valid = (a_stim_q.size() > 0);
      bus.a_code  = (a_stim_q.size() > 0) ? a_stim_q[0] : 7'd0;
      bus.b_valid = (b_stim_q.size() > 0);
      bus.b_code  = (b_stim_q.size() > 0) ? b_stim_q[0] : 7'd0;
    end
  end

  // Monitor: decides what the next rising edge does, keeps scoreboard and counter model.
  initial forever begin
    exp_t e;
    logic [4:0] r;
    logic cur;
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
      a_hs = 1'b0; b_hs = 1'b0; prev_stall = 1'b0; last_src = 1'b1;
      exp_cnt_a = '0; exp_cnt_b = '0;
    end else begin
      a_hs = bus.a_valid & bus.a_ready;
      b_hs = bus.b_valid & bus.b_ready;
      if (bus.a_ready & bus.b_ready) excl_viol++;
      if (prev_stall && ({bus.out_valid, bus.out_src, bus.out_corrected, bus.out_data} != {1'b1, prev_out}))
        hold_viol++;
      if (bus.out_valid & bus.out_ready) begin
        if (tp_first < 0) tp_first = cycle;
        tp_last = cycle;
        if (sb_q.size() == 0) spurious++;
        else begin
          e = sb_q.pop_front();
          chk("out_src", bus.out_src, e.src);
          chk("out_data", bus.out_data, e.data);
          chk("out_corrected", bus.out_corrected, e.corr);
          if (e.acc_cyc > last_stall) chk("latency", cycle - e.acc_cyc, 2);
          if (e.corr) begin
            if (e.src) begin if (exp_cnt_b != '1) exp_cnt_b = exp_cnt_b + 1'b1; end
            else begin if (exp_cnt_a != '1) exp_cnt_a = exp_cnt_a + 1'b1; end
          end
        end
      end
      if (bus.cnt_clr) begin exp_cnt_a = '0; exp_cnt_b = '0; end
      if (a_hs | b_hs) begin
        cur = b_hs;
        if (bus.a_valid && bus.b_valid && cur == last_src) alt_viol++;
        last_src = cur;
        r = ref_dec(b_hs ? bus.b_code : bus.a_code);
        sb_q.push_back('{cur, r[3:0], r[4], cycle});
      end
      prev_stall = bus.out_valid & !bus.out_ready;
      if (prev_stall) last_stall = cycle;
      prev_out = {bus.out_src, bus.out_corrected, bus.out_data};
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (a_stim_q.size() != 0 || b_stim_q.size() != 0 || sb_q.size() != 0 || bus.out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > budget) begin
        chk("idle_timeout", n, budget);
        break;
      end
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 30) begin
        chk(tag, n, 30);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    bus.cnt_clr = 1'b0;
    a_stim_q.push_back(enc(4'b1010));
    repeat (3) @(posedge clk);
    #3;
    chk("rst_out", {bus.out_valid, bus.out_src, bus.out_corrected, bus.out_data}, 0);
    chk("rst_ready", {bus.a_ready, bus.b_ready}, 0);
    chk("rst_cnt_a", bus.err_cnt_a, 0);
    chk("rst_cnt_b", bus.err_cnt_b, 0);
    rst_n = 1'b1;

    // Clean word from A.
    wait_idle(50);
    chk("clean_cnt_a", bus.err_cnt_a, 0);

    // Single-bit sweep on A, including the c3 flip.
    for (int i = 0; i < 7; i++) a_stim_q.push_back(mk_code(4'b1010, i));
    wait_idle(100);
    chk("sweep_cnt_a", bus.err_cnt_a, 7);
    chk("sweep_cnt_a_model", bus.err_cnt_a, exp_cnt_a);

    // Contention: both held valid, full throughput.
    tp_first = -1;
    for (int i = 0; i < 20; i++) begin
      a_stim_q.push_back(mk_code(4'($urandom_range(0, 15)), int'($urandom_range(0, 7))));
      b_stim_q.push_back(mk_code(4'($urandom_range(0, 15)), int'($urandom_range(0, 7))));
    end
    wait_idle(200);
    chk("throughput", tp_last - tp_first + 1, 40);

    // Backpressure for 5 cycles, then a random out_ready pattern.
    for (int i = 0; i < 12; i++) begin
      a_stim_q.push_back(mk_code(4'(i), i % 8));
      b_stim_q.push_back(mk_code(4'(15 - i), (i + 3) % 8));
    end
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_ready", {bus.a_ready, bus.b_ready}, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.out_ready = 1'b1;
    wait_idle(300);

    // Saturation on B.
    for (int i = 0; i < 17; i++) b_stim_q.push_back(mk_code(4'(i), 2));
    wait_idle(200);
    chk("sat_cnt_b", bus.err_cnt_b, 15);
    chk("sat_cnt_b_model", bus.err_cnt_b, exp_cnt_b);
    chk("sat_cnt_a_model", bus.err_cnt_a, exp_cnt_a);

    // Clear coinciding with a corrected B output.
    b_stim_q.push_back(mk_code(4'h6, 5));
    wait_out_valid("clr_wait_timeout");
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    chk("clr_cnt_b", bus.err_cnt_b, 0);
    chk("clr_cnt_a", bus.err_cnt_a, 0);
    wait_idle(50);
    chk("clr_cnt_b_model", bus.err_cnt_b, exp_cnt_b);

    a_stim_q.push_back(mk_code(4'h3, 0));
    a_stim_q.push_back(mk_code(4'hC, 6));
    wait_idle(50);
    chk("post_clr_cnt_a", bus.err_cnt_a, 2);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 8; i++) begin
      a_stim_q.push_back(mk_code(4'(i), 1));
      b_stim_q.push_back(mk_code(4'(i + 8), 4));
    end
    wait_out_valid("mid_rst_wait_timeout");
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_cnt_a", bus.err_cnt_a, 0);
    chk("mid_rst_cnt_b", bus.err_cnt_b, 0);
    chk("mid_rst_ready", {bus.a_ready, bus.b_ready}, 0);
    a_stim_q.delete();
    b_stim_q.delete();
    repeat (2) @(posedge clk);
    #1;

    // After reset, A wins the first tie.
    rst_n = 1'b1;
    a_stim_q.push_back(enc(4'h3));
    b_stim_q.push_back(enc(4'hC));
    n = 0;
    while (!(bus.a_ready | bus.b_ready) && n < 10) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk("tie_first_grant", {bus.a_valid, bus.b_valid, bus.a_ready, bus.b_ready}, 4'b1110);
    wait_idle(50);
    chk("post_rst_cnt_b", bus.err_cnt_b, 0);

    chk("ready_exclusive", excl_viol, 0);
    chk("round_robin", alt_viol, 0);
    chk("stall_hold", hold_viol, 0);
    chk("spurious_out", spurious, 0);
    chk("sb_leftover", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
